// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage for the MIPS pipeline. It contains:
//   * a PC generator with sign-extended, word-scaled branch redirection,
//   * a pipelined request/response interface to a one-cycle-latency
//     instruction memory,
//   * a small circular prefetch queue that decouples fetch from decode.
//
// Optional feature: define IF_PERF_CNT_EN to add the fetchCount/flushCount
// performance counters. Fetch behaviour is identical with or without them.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   imemReq        out  fetch request this cycle
//   imemAddr       out  request address (equals fetchPC even when idle)
//   imemInst       in   instruction, valid one cycle after its request
//   brTaken        in   redirect/flush strobe
//   brPC           in   branch base (PC of branch + 4)
//   brOffset       in   signed branch offset in words
//   outValid       out  queue head valid
//   outReady       in   decode accepts the head
//   outPC          out  PC of the head instruction (0 when empty)
//   outInstruction out  head instruction (0 when empty)
//   fetchCount     out  accepted pops, wraps at 2^32   (IF_PERF_CNT_EN only)
//   flushCount     out  cycles with brTaken, wraps     (IF_PERF_CNT_EN only)
//
// Handshake: the head moves to decode on a cycle where outValid && outReady
// are both high at the rising edge; outValid never depends on outReady, and
// the head is held stable until it is taken or flushed by brTaken.
// -----------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int unsigned          INST_SIZE      = 32,
    parameter int unsigned          PC_SIZE        = 32,
    parameter int unsigned          BR_OFFSET_SIZE = 16,
    parameter int unsigned          QUEUE_DEPTH    = 4,
    parameter logic [PC_SIZE-1:0]   RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imemReq,
    output logic [PC_SIZE-1:0]        imemAddr,
    input  logic [INST_SIZE-1:0]      imemInst,
    input  logic                      brTaken,
    input  logic [PC_SIZE-1:0]        brPC,
    input  logic [BR_OFFSET_SIZE-1:0] brOffset,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [PC_SIZE-1:0]        outPC,
    output logic [INST_SIZE-1:0]      outInstruction
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]               fetchCount,
    output logic [31:0]               flushCount
`endif
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // Depth widened by one bit so it can be compared against count + inflight.
    localparam logic [CNT_W:0] DEPTH_EXT = QUEUE_DEPTH[CNT_W:0];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PC_SIZE-1:0]   fetch_pc_q,       fetch_pc_d;
    logic                 inflight_valid_q, inflight_valid_d;
    logic [PC_SIZE-1:0]   inflight_pc_q,    inflight_pc_d;
    logic [PTR_W-1:0]     wr_ptr_q,         wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,         rd_ptr_d;
    logic [CNT_W-1:0]     count_q,          count_d;

    logic [PC_SIZE-1:0]   q_pc_q   [QUEUE_DEPTH];
    logic [INST_SIZE-1:0] q_inst_q [QUEUE_DEPTH];

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [CNT_W:0]       occupancy;
    logic [PC_SIZE-1:0]   br_off_ext;
    logic [PC_SIZE-1:0]   br_target;

    assign outValid = (count_q != '0);

    // A redirect flushes the head, so a simultaneous handshake is not a pop.
    assign pop  = outValid && outReady && !brTaken;
    // The response of a flushed in-flight request is dropped.
    assign push = inflight_valid_q && !brTaken;

    // Slots already claimed once this cycle's pop is credited. A pop implies
    // count_q >= 1, so the subtraction never underflows.
    assign occupancy = {1'b0, count_q}
                     + {{CNT_W{1'b0}}, inflight_valid_q}
                     - {{CNT_W{1'b0}}, pop};

    // rst gates the request combinationally so imemReq drops the moment reset
    // is asserted rather than waiting for the registers to settle.
    assign issue = rst && !brTaken && (occupancy < DEPTH_EXT);

    // Offset is in words: sign-extend to PC width, then scale by 4. Bits
    // shifted out of the top are discarded, giving modulo-2^PC_SIZE targets.
    // Assumes PC_SIZE > BR_OFFSET_SIZE.
    assign br_off_ext = {{(PC_SIZE-BR_OFFSET_SIZE){brOffset[BR_OFFSET_SIZE-1]}}, brOffset};
    assign br_target  = brPC + (br_off_ext << 2);

    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;

        if (brTaken) begin
            fetch_pc_d       = br_target;
            inflight_valid_d = 1'b0;
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
        end else begin
            if (issue) begin
                fetch_pc_d       = fetch_pc_q + PC_SIZE'(4);
                inflight_valid_d = 1'b1;
                inflight_pc_d    = fetch_pc_q;
            end else begin
                inflight_valid_d = 1'b0;
            end
            // Pointer widths equal log2(depth), so increments wrap naturally.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + {{(CNT_W-1){1'b0}}, push}
                              - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q       <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]   <= inflight_pc_q;
            q_inst_q[wr_ptr_q] <= imemInst;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imemReq        = issue;
    assign imemAddr       = fetch_pc_q;
    assign outPC          = outValid ? q_pc_q[rd_ptr_q]   : '0;
    assign outInstruction = outValid ? q_inst_q[rd_ptr_q] : '0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (brTaken) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed bench for if_fetch_queue (default parameters). A table of
// per-cycle vectors holds the inputs and the hand-computed outputs; the
// instruction memory answers each request one cycle later with the word
// address (addr >> 2) as data. Accepted pops are also checked in order
// against an expected queue of PCs. Reset behaviour is checked by hand.
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemInst;
    logic        brTaken;
    logic [31:0] brPC;
    logic [15:0] brOffset;
    logic        outValid;
    logic        outReady;
    logic [31:0] outPC;
    logic [31:0] outInstruction;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCount;
    logic [31:0] flushCount;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemInst       (imemInst),
        .brTaken        (brTaken),
        .brPC           (brPC),
        .brOffset       (brOffset),
        .outValid       (outValid),
        .outReady       (outReady),
        .outPC          (outPC),
`ifdef IF_PERF_CNT_EN
        .fetchCount     (fetchCount),
        .flushCount     (flushCount),
`endif
        .outInstruction (outInstruction)
    );

    // -------------------------------------------------------------------------
    // Vectors, scoreboard, counters
    // -------------------------------------------------------------------------
    typedef struct {
        logic        out_ready;
        logic        br_taken;
        logic [31:0] br_pc;
        logic [15:0] br_off;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks;
    int          failures;
    logic        prev_req;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic br, input logic [31:0] bpc,
                       input logic [15:0] boff, input logic req, input logic [31:0] addr,
                       input logic v, input logic [31:0] pc);
        vec_t r;
        r.out_ready = rdy;
        r.br_taken  = br;
        r.br_pc     = bpc;
        r.br_off    = boff;
        r.exp_req   = req;
        r.exp_addr  = addr;
        r.exp_valid = v;
        r.exp_pc    = pc;
        vecs.push_back(r);
    endtask

    // Called at a falling edge; returns at the next falling edge per row.
    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            vec_t        r;
            logic [31:0] exp_inst;
            logic [31:0] got_pc;
            r = vecs[i];
            imemInst = prev_req ? mem_data(prev_addr) : 32'hDEAD_BEEF;
            outReady = r.out_ready;
            brTaken  = r.br_taken;
            brPC     = r.br_pc;
            brOffset = r.br_off;
            #1;
            exp_inst = r.exp_valid ? mem_data(r.exp_pc) : 32'h0;
            check_bit ($sformatf("%s[%0d] imemReq", tag, i - lo), imemReq, r.exp_req);
            check_word($sformatf("%s[%0d] imemAddr", tag, i - lo), imemAddr, r.exp_addr);
            check_bit ($sformatf("%s[%0d] outValid", tag, i - lo), outValid, r.exp_valid);
            check_word($sformatf("%s[%0d] outPC", tag, i - lo), outPC, r.exp_valid ? r.exp_pc : 32'h0);
            check_word($sformatf("%s[%0d] outInstruction", tag, i - lo), outInstruction, exp_inst);
            // Scoreboard: every accepted pop must be the next expected PC.
            if (outValid && outReady && !brTaken) begin
                got_pc = outPC;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s[%0d] pop: got unexpected pop of 0x%08h expected none", tag, i - lo, got_pc);
                end else begin
                    check_word($sformatf("%s[%0d] pop order", tag, i - lo), got_pc, exp_q.pop_front());
                end
            end
            prev_req  = imemReq;
            prev_addr = imemAddr;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pops: got %0d missing expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit ({tag, " imemReq"},        imemReq,        1'b0);
        check_word({tag, " imemAddr"},       imemAddr,       32'h0);
        check_bit ({tag, " outValid"},       outValid,       1'b0);
        check_word({tag, " outPC"},          outPC,          32'h0);
        check_word({tag, " outInstruction"}, outInstruction, 32'h0);
`ifdef IF_PERF_CNT_EN
        check_word({tag, " fetchCount"},     fetchCount,     32'h0);
        check_word({tag, " flushCount"},     flushCount,     32'h0);
`endif
    endtask

    // -------------------------------------------------------------------------
    // Test
    // -------------------------------------------------------------------------
    initial begin
        checks    = 0;
        failures  = 0;
        prev_req  = 1'b0;
        prev_addr = 32'h0;
        rst       = 1'b0;
        imemInst  = 32'h0;
        brTaken   = 1'b0;
        brPC      = 32'h0;
        brOffset  = 16'h0;
        outReady  = 1'b1;

        // Sequence A (rows 0..15): streaming, forward and backward branch.
        //   rdy br  brPC          off      req addr          v  pc
        add(1, 0, 32'h0,        16'h0,    1, 32'h00,       0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h04,       0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h08,       1, 32'h00);
        add(1, 0, 32'h0,        16'h0,    1, 32'h0C,       1, 32'h04);
        add(1, 0, 32'h0,        16'h0,    1, 32'h10,       1, 32'h08);
        add(1, 0, 32'h0,        16'h0,    1, 32'h14,       1, 32'h0C);
        add(1, 1, 32'h10,       16'h3,    0, 32'h18,       1, 32'h10);
        add(1, 0, 32'h0,        16'h0,    1, 32'h1C,       0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h20,       0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h24,       1, 32'h1C);
        add(1, 0, 32'h0,        16'h0,    1, 32'h28,       1, 32'h20);
        add(1, 1, 32'h40,       16'hFFFF, 0, 32'h2C,       1, 32'h24);
        add(1, 0, 32'h0,        16'h0,    1, 32'h3C,       0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h40,       0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h44,       1, 32'h3C);
        add(1, 0, 32'h0,        16'h0,    1, 32'h48,       1, 32'h40);
        // Sequence B (rows 16..44): backpressure, flush of a full queue,
        // held brTaken, PC wrap-around.
        add(0, 0, 32'h0,        16'h0,    1, 32'h00,       0, 32'h0);
        add(0, 0, 32'h0,        16'h0,    1, 32'h04,       0, 32'h0);
        add(0, 0, 32'h0,        16'h0,    1, 32'h08,       1, 32'h00);
        add(0, 0, 32'h0,        16'h0,    1, 32'h0C,       1, 32'h00);
        add(0, 0, 32'h0,        16'h0,    0, 32'h10,       1, 32'h00);
        add(0, 0, 32'h0,        16'h0,    0, 32'h10,       1, 32'h00);
        add(0, 0, 32'h0,        16'h0,    0, 32'h10,       1, 32'h00);
        add(1, 0, 32'h0,        16'h0,    1, 32'h10,       1, 32'h00);
        add(1, 0, 32'h0,        16'h0,    1, 32'h14,       1, 32'h04);
        add(1, 0, 32'h0,        16'h0,    1, 32'h18,       1, 32'h08);
        add(1, 0, 32'h0,        16'h0,    1, 32'h1C,       1, 32'h0C);
        add(1, 0, 32'h0,        16'h0,    1, 32'h20,       1, 32'h10);
        add(1, 0, 32'h0,        16'h0,    1, 32'h24,       1, 32'h14);
        add(0, 0, 32'h0,        16'h0,    0, 32'h28,       1, 32'h18);
        add(1, 1, 32'h100,      16'h0,    0, 32'h28,       1, 32'h18);
        add(1, 0, 32'h0,        16'h0,    1, 32'h100,      0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h104,      0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h108,      1, 32'h100);
        add(1, 1, 32'h200,      16'h1,    0, 32'h10C,      1, 32'h104);
        add(1, 1, 32'h200,      16'h1,    0, 32'h204,      0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h204,      0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h208,      0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h20C,      1, 32'h204);
        add(1, 1, 32'hFFFFFFF8, 16'h0,    0, 32'h210,      1, 32'h208);
        add(1, 0, 32'h0,        16'h0,    1, 32'hFFFFFFF8, 0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'hFFFFFFFC, 0, 32'h0);
        add(1, 0, 32'h0,        16'h0,    1, 32'h00,       1, 32'hFFFFFFF8);
        add(1, 0, 32'h0,        16'h0,    1, 32'h04,       1, 32'hFFFFFFFC);
        add(1, 0, 32'h0,        16'h0,    1, 32'h08,       1, 32'h00);

        // Reset state, held across a couple of edges.
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // Release at a falling edge: the first request is in this cycle.
        @(negedge clk);
        rst = 1'b1;
        exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h1C, 32'h20, 32'h3C, 32'h40};
        run_rows(0, 16, "A");

        // Reset asserted asynchronously between edges while streaming.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        prev_req = 1'b0;
        exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                  32'h100, 32'h204, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00};
        run_rows(16, 45, "B");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage for the MIPS pipeline. It replaces the single-register fetch stage with several additions:
- a PC generator with sign-extended, word-scaled branch redirection;
- a pipelined request/response interface to a one-cycle-latency instruction memory;
- a small prefetch queue that decouples fetch from decode through a valid/ready handshake.

It sits between the instruction memory and the IF/ID boundary. Branch resolution from later stages redirects it and flushes it.

## Interface
Parameters:
- INST_SIZE, 32, instruction width
- PC_SIZE, 32, PC/address width
- BR_OFFSET_SIZE, 16, branch offset width (signed, in words)
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 0, PC fetched first after reset

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imemReq  out  1  fetch request this cycle
- imemAddr  out  PC_SIZE  address of the request
- imemInst  in  INST_SIZE  instruction; valid exactly one cycle after the request
- brTaken  in  1  redirect/flush strobe
- brPC  in  PC_SIZE  branch base (PC of branch + 4)
- brOffset  in  BR_OFFSET_SIZE  signed word offset
- outValid  out  1  queue head valid
- outReady  in  1  decode accepts the head
- outPC  out  PC_SIZE  PC of the head instruction
- outInstruction  out  INST_SIZE  head instruction

## Operation
- State:
  - fetchPC register;
  - in-flight register: a valid bit plus the PC of the outstanding request;
  - circular queue of {PC, instruction} entries with read/write pointers and a count (0..QUEUE_DEPTH).
- Pop: occurs when outValid && outReady.
- Request issue:
  - imemReq=1 when (count + inflightValid − pop) < QUEUE_DEPTH and brTaken=0.
  - On issue: imemAddr=fetchPC; fetchPC ← fetchPC+4; inflight ← {1, fetchPC}.
  - Without issue, inflightValid ← 0.
- imemAddr: equals fetchPC when imemReq=0; the memory ignores it.
- Response: when inflightValid=1, imemInst and the in-flight PC are written at the write pointer, and count increments. The issue credit guarantees there is never a push into a full queue.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Redirect, when brTaken=1:
  - fetchPC ← brPC + (sign_extend(brOffset) << 2), computed modulo 2^PC_SIZE;
  - the queue is cleared (count=0, pointers=0);
  - the in-flight response is discarded and inflightValid ← 0;
  - no request is issued that cycle;
  - any pop that cycle is ignored, because the head is being flushed.
- Empty queue: outValid=0; outPC and outInstruction are driven to 0.
- Wrap-around:
  - pointers wrap modulo QUEUE_DEPTH;
  - fetchPC wraps modulo 2^PC_SIZE with no error.

## Timing
- Reset, asserted asynchronously:
  - fetchPC=RESET_PC; inflightValid=0; count=0;
  - imemReq=0, outValid=0, outPC=0, outInstruction=0.
- First request: in the first rising edge cycle after rst deasserts.
- Latency: a request in cycle n is captured at the end of cycle n+1, so outValid=1 in cycle n+2. Latency is 2 cycles from request to head.
- Throughput: 1 instruction/cycle sustained with outReady=1 (steady state count=1, one in flight).
- Backpressure: with outReady=0, at most QUEUE_DEPTH instructions are buffered, and imemReq drops in the cycle count+inflight reaches QUEUE_DEPTH. No instruction is lost or duplicated.
- Redirect penalty:
  - brTaken in cycle n → first request to the target in cycle n+1;
  - the target is at the head (outValid) in cycle n+3.
- brTaken held for multiple cycles: each cycle re-redirects and flushes; fetch resumes the cycle after it deasserts.
- Reset mid-operation: all state clears immediately; the in-flight response is dropped.

## Configuration
- IF_PERF_CNT_EN: when defined, adds outputs fetchCount and flushCount, each 32 bits.
  - fetchCount increments on each accepted pop.
  - flushCount increments on each cycle with brTaken=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist. Fetch behaviour is identical either way.

## Test plan
- Reset release, outReady=1, memory returns word address as data:
  - imemAddr 0x0, 0x4, 0x8… on consecutive cycles;
  - outValid rises 2 cycles after the first request;
  - outPC 0x0, 0x4, 0x8 with one instruction per cycle.
- Backpressure, QUEUE_DEPTH=4:
  - hold outReady=0 from the start → imemReq totals 4 requests then stays 0; count=4;
  - release outReady → heads 0x0, 0x4, 0x8, 0xC then 0x10 with no gaps or duplicates.
- Forward branch, brTaken with brPC=0x10, brOffset=3:
  - next imemAddr is 0x1C;
  - the in-flight instruction is dropped;
  - the next outPC after the flush is 0x1C, 3 cycles after brTaken.
- Backward branch, brPC=0x40, brOffset=0xFFFF → target 0x3C.
- Branch while the queue is full and outReady=1 in the same cycle:
  - queue empties with no pop of stale data;
  - outValid=0 for the next 2 cycles.
- Reset mid-stream:
  - assert rst asynchronously between edges → outValid, imemReq, outPC drop to 0 immediately;
  - after release, fetch restarts at RESET_PC;
  - with IF_PERF_CNT_EN, both counters read 0.
